// File: rtl/rca4_slice_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rca4_slice_sched
//  Purpose  : Shares one external 4-bit ripple-carry adder slice between two
//             requesters. Each WIDTH-bit add runs as WIDTH/4 nibble passes,
//             least significant nibble first, with the carry held in a
//             register between passes. Round-robin arbitration, valid/ready
//             handshakes on both request and response sides.
//  Revision : 1.0  initial release
// ============================================================================
module rca4_slice_sched #(
    parameter int WIDTH = 16    // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_ci,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_ci,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_co,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_s,
    input  logic             add_co
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_q;
    logic             last_grant_q;

    logic             w_idle;
    logic             w_run;
    logic             w_take0;
    logic             w_take1;

    assign w_idle = (state_q == S_IDLE);
    assign w_run  = (state_q == S_RUN);

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    assign w_take0 = w_idle & req0_valid & (~req1_valid | last_grant_q);
    assign w_take1 = w_idle & req1_valid & (~req0_valid | ~last_grant_q);

    // Ready is masked during reset so every output reads 0 while rst is high.
    assign req0_ready = w_take0 & ~rst;
    assign req1_ready = w_take1 & ~rst;

    // Response side comes straight from the holding registers.
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_co    = carry_q;

    // Slice inputs carry the current low nibble only while running.
    assign add_a  = w_run ? opa_q[3:0] : 4'd0;
    assign add_b  = w_run ? opb_q[3:0] : 4'd0;
    assign add_ci = w_run ? carry_q    : 1'b0;

    // New slice result enters at the top; after NSLICE passes the sum is aligned.
    always_comb begin
        sum_d              = sum_q >> 4;
        sum_d[WIDTH-1 -: 4] = add_s;
    end

    // Scheduler state machine and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            opa_q        <= '0;
            opb_q        <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_take0) begin
                        opa_q        <= req0_a;
                        opb_q        <= req0_b;
                        carry_q      <= req0_ci;
                        id_q         <= 1'b0;
                        last_grant_q <= 1'b0;
                        cnt_q        <= '0;
                        sum_q        <= '0;
                        state_q      <= S_RUN;
                    end else if (w_take1) begin
                        opa_q        <= req1_a;
                        opb_q        <= req1_b;
                        carry_q      <= req1_ci;
                        id_q         <= 1'b1;
                        last_grant_q <= 1'b1;
                        cnt_q        <= '0;
                        sum_q        <= '0;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    opa_q   <= opa_q >> 4;
                    opb_q   <= opb_q >> 4;
                    carry_q <= add_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == C_CNT_LAST) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rca4_slice_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rca4_slice_sched
//  Purpose  : Self-checking bench for rca4_slice_sched with a behavioural
//             adder slice, per-requester drivers, and a scoreboard monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rca4_slice_sched;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ci = 1'b0, req1_ci = 1'b0;
    logic             rsp_valid, rsp_id, rsp_co;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_sum;
    logic [3:0]       add_a, add_b, add_s;
    logic             add_ci, add_co;

    rca4_slice_sched #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_co(rsp_co),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co)
    );

    // The shared slice lives outside the DUT: plain 4-bit add.
    assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; logic ci; } op_t;
    typedef struct { logic id; logic [WIDTH-1:0] sum; logic co; } rsp_t;

    op_t  q0[$], q1[$];
    rsp_t sb[$];
    rsp_t rsp_log[$];
    int   gorder[$];

    int checks = 0, passed = 0;
    int rr_mode = 2;         // 0 random, 1 held low, 2 held high
    int use_gaps = 0;

    // Reference-model state
    logic             busy = 1'b0, lg_m = 1'b1;
    int               run_start = 0, done_cyc = 0;
    logic [WIDTH-1:0] ra = '0, rb = '0;
    logic             rci = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Requester 0 driver
    initial begin : drv0
        logic hs; int gap;
        gap = 0;
        forever begin
            @(negedge clk);
            hs = req0_valid && req0_ready && !rst;
            @(posedge clk); #1;
            if (hs) begin
                void'(q0.pop_front());
                req0_valid = 1'b0;
                req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_ci = 1'($urandom);
                gap = use_gaps ? $urandom_range(0, 2) : 0;
            end
            if (gap > 0) gap--;
            else if (!req0_valid && q0.size() > 0) begin
                req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_ci = q0[0].ci;
            end
        end
    end

    // Requester 1 driver
    initial begin : drv1
        logic hs; int gap;
        gap = 0;
        forever begin
            @(negedge clk);
            hs = req1_valid && req1_ready && !rst;
            @(posedge clk); #1;
            if (hs) begin
                void'(q1.pop_front());
                req1_valid = 1'b0;
                req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_ci = 1'($urandom);
                gap = use_gaps ? $urandom_range(0, 2) : 0;
            end
            if (gap > 0) gap--;
            else if (!req1_valid && q1.size() > 0) begin
                req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_ci = q1[0].ci;
            end
        end
    end

    // Response consumer
    initial begin : rdy
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: model of arbitration, nibble schedule and results
    initial begin : mon
        logic e0, e1, was_busy, gid;
        logic [WIDTH:0] full;
        logic [63:0] a64, b64, m, pc;
        int k;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete(); busy = 1'b0; lg_m = 1'b1;
            end else begin
                was_busy = busy;
                if (was_busy) begin e0 = 1'b0; e1 = 1'b0; end
                else if (req0_valid && req1_valid) begin e0 = lg_m; e1 = !lg_m; end
                else begin e0 = req0_valid; e1 = req1_valid; end
                chk("req0_ready", 64'(req0_ready), 64'(e0));
                chk("req1_ready", 64'(req1_ready), 64'(e1));
                if (req0_valid && req0_ready) gorder.push_back(0);
                if (req1_valid && req1_ready) gorder.push_back(1);

                if (was_busy && cyc >= run_start && cyc < run_start + NSLICE) begin
                    k = cyc - run_start;
                    a64 = 64'(ra); b64 = 64'(rb);
                    m = (64'd1 << (4 * k)) - 64'd1;
                    pc = (a64 & m) + (b64 & m) + 64'(rci);
                    chk("add_a", 64'(add_a), (a64 >> (4 * k)) & 64'hF);
                    chk("add_b", 64'(add_b), (b64 >> (4 * k)) & 64'hF);
                    chk("add_ci", 64'(add_ci), 64'(pc[4 * k]));
                end else begin
                    chk("add_idle", 64'({add_a, add_b, add_ci}), 64'd0);
                end

                chk("rsp_valid", 64'(rsp_valid), 64'(was_busy && cyc >= done_cyc));
                if (rsp_valid && sb.size() > 0) begin
                    chk("rsp_id",  64'(rsp_id),  64'(sb[0].id));
                    chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
                    chk("rsp_co",  64'(rsp_co),  64'(sb[0].co));
                    if (rsp_ready) begin
                        r.id = rsp_id; r.sum = rsp_sum; r.co = rsp_co;
                        rsp_log.push_back(r);
                        void'(sb.pop_front());
                        busy = 1'b0;
                    end
                end

                if (!was_busy && (e0 || e1)) begin
                    gid = e1;
                    ra  = gid ? req1_a  : req0_a;
                    rb  = gid ? req1_b  : req0_b;
                    rci = gid ? req1_ci : req0_ci;
                    full = (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rci);
                    r.id = gid; r.sum = full[WIDTH-1:0]; r.co = full[WIDTH];
                    sb.push_back(r);
                    busy = 1'b1; lg_m = gid;
                    run_start = cyc + 1;
                    done_cyc  = cyc + NSLICE + 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < lim) begin
            step(); n++;
        end
        chk("drain", 64'(q0.size() == 0 && q1.size() == 0 && !busy), 64'd1);
        repeat (2) step();
    endtask

    function automatic op_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        op_t o;
        o.a = a; o.b = b; o.ci = ci;
        return o;
    endfunction

    function automatic logic [WIDTH-1:0] rval();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return WIDTH'(1) << (WIDTH - 1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin : main
        int n;
        #1 rst = 1'b1;
        // Tie from reset: expect order 0,1,0,1 with the directed sums
        q0.push_back(mk(16'h1234, 16'h4321, 1'b0));
        q0.push_back(mk(16'hFFFF, 16'h0000, 1'b1));
        q1.push_back(mk(16'hFFFF, 16'h0001, 1'b0));
        q1.push_back(mk(16'h8000, 16'h8000, 1'b0));
        repeat (3) step();
        chk("reset_outputs", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum,
                                  rsp_co, add_a, add_b, add_ci}), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        drain(200);
        chk("grant_count", 64'(gorder.size()), 64'd4);
        chk("rsp_count",   64'(rsp_log.size()), 64'd4);
        if (gorder.size() == 4 && rsp_log.size() == 4) begin
            chk("grant_order", {gorder[0][1:0], gorder[1][1:0], gorder[2][1:0], gorder[3][1:0]}, 64'b00_01_00_01);
            chk("dir0", 64'({rsp_log[0].id, rsp_log[0].co, rsp_log[0].sum}), 64'h0_5555);
            chk("dir1", 64'({rsp_log[1].id, rsp_log[1].co, rsp_log[1].sum}), 64'h3_0000);
            chk("dir2", 64'({rsp_log[2].id, rsp_log[2].co, rsp_log[2].sum}), 64'h1_0000);
            chk("dir3", 64'({rsp_log[3].id, rsp_log[3].co, rsp_log[3].sum}), 64'h3_0000);
        end

        // Back-pressure: response held for 10 cycles, a pending request must wait
        rr_mode = 1;
        q0.push_back(mk(16'hA5A5, 16'h5A5B, 1'b1));
        n = 0;
        while (!rsp_valid && n < 50) begin step(); n++; end
        chk("stall_rsp_seen", 64'(rsp_valid), 64'd1);
        q1.push_back(mk(16'h0F0F, 16'hF0F1, 1'b0));
        repeat (10) step();
        chk("stall_still_valid", 64'(rsp_valid), 64'd1);
        rr_mode = 2;
        drain(200);

        // Async reset on the 2nd RUN cycle aborts the operation
        q1.push_back(mk(16'h7777, 16'h1111, 1'b1));
        n = 0;
        while (!(busy && cyc == run_start + 1) && n < 50) begin step(); n++; end
        chk("reset_run_reached", 64'(busy && cyc == run_start + 1), 64'd1);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum,
                                           rsp_co, add_a, add_b, add_ci}), 64'd0);
        n = rsp_log.size();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        gorder.delete();
        q0.push_back(mk(16'h1357, 16'h2468, 1'b0));
        q1.push_back(mk(16'h9999, 16'h6667, 1'b0));
        drain(200);
        chk("abort_no_rsp", 64'(rsp_log.size()), 64'(n + 2));
        chk("post_reset_first_grant", 64'(gorder.size() > 0 ? gorder[0] : 9), 64'd0);

        // Randomized traffic with random gaps and random back-pressure
        rr_mode = 0; use_gaps = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(mk(rval(), rval(), 1'($urandom)));
            else                           q1.push_back(mk(rval(), rval(), 1'($urandom)));
        end
        drain(6000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
